// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the sync-decoder state encoding.
// Imported by the timing generator and by the receive-side decoder.
package vga_pkg;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned H_OFFSET = 160;
  localparam int unsigned V_OFFSET = 50;
  localparam int unsigned ACTIVE_W = 576;
  localparam int unsigned ACTIVE_H = 448;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

endpackage

// File: rtl/vga_edge_counter.sv
// Falling-edge detector on a sampled sync line plus a saturating position
// counter that captures the measured period length at every detected edge.
module vga_edge_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         sig,
  output logic         fall,
  output logic [W-1:0] count,
  output logic [W-1:0] len
);

  logic prev;

  // prev only advances on en, so for the vertical unit it holds the
  // vsync level seen at the previous line start.
  assign fall = en & prev & ~sig;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev  <= 1'b1;
      count <= '0;
      len   <= '0;
    end else if (en) begin
      prev <= sig;
      if (fall) begin
        count <= '0;
        len   <= count + 1'b1;
      end else if (count != '1) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from an hsync/vsync/bright stream, measures
// line/frame lengths, tracks lock and counts bright-window mismatches.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL     = vga_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int unsigned H_OFFSET    = vga_pkg::H_OFFSET,
  parameter int unsigned V_OFFSET    = vga_pkg::V_OFFSET,
  parameter int unsigned ACTIVE_W    = vga_pkg::ACTIVE_W,
  parameter int unsigned ACTIVE_H    = vga_pkg::ACTIVE_H,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_ce,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        bright_in,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] bright_err_cnt,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines
);

  import vga_pkg::*;

  localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [9:0]    H_NOM    = 10'(H_TOTAL);
  localparam logic [9:0]    V_NOM    = 10'(V_TOTAL);
  localparam logic [GW-1:0] LOCK_CNT = GW'(LOCK_FRAMES);
  localparam logic [10:0]   HLO = 11'(H_OFFSET);
  localparam logic [10:0]   HHI = 11'(H_OFFSET + ACTIVE_W);
  localparam logic [10:0]   VLO = 11'(V_OFFSET);
  localparam logic [10:0]   VHI = 11'(V_OFFSET + ACTIVE_H);

  sync_state_t   state, state_n;
  logic [GW-1:0] good_frames, good_n, good_inc;
  logic          line_bad, line_bad_n;
  logic          hfall, vfall, timeout, lock_err, line_bad_now, frame_len_ok;
  logic [9:0]    h_meas, v_meas;
  logic [10:0]   px, py;
  logic          bright_exp;

  vga_edge_counter #(.W(10)) u_horz (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pix_ce),
    .sig     (hsync_in),
    .fall    (hfall),
    .count   (x_out),
    .len     (line_len)
  );

  vga_edge_counter #(.W(10)) u_vert (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (hfall),
    .sig     (vsync_in),
    .fall    (vfall),
    .count   (y_out),
    .len     (frame_lines)
  );

  // Judge the lengths being captured on this edge, not the stale registers.
  assign h_meas       = x_out + 10'd1;
  assign v_meas       = y_out + 10'd1;
  assign line_bad_now = hfall & (h_meas != H_NOM);
  assign frame_len_ok = (v_meas == V_NOM);
  // Fires only on the step into saturation, so a stuck hsync pulses once.
  assign timeout      = pix_ce & ~hfall & (x_out == 10'd1022);
  assign good_inc     = good_frames + 1'b1;

  assign px = {1'b0, x_out};
  assign py = {1'b0, y_out};
  assign bright_exp = (px > HLO) && (px < HHI) && (py > VLO) && (py < VHI);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= SEARCH;
      good_frames <= '0;
      line_bad    <= 1'b0;
    end else begin
      state       <= state_n;
      good_frames <= good_n;
      line_bad    <= line_bad_n;
    end
  end

  always_comb begin
    state_n    = state;
    good_n     = good_frames;
    line_bad_n = line_bad;
    lock_err   = 1'b0;
    case (state)
      SEARCH: begin
        if (vfall) begin
          state_n    = CHECK;
          good_n     = '0;
          line_bad_n = 1'b0;
        end
      end
      CHECK: begin
        if (timeout) begin
          state_n = SEARCH;
        end else if (vfall) begin
          line_bad_n = 1'b0;
          if (!(line_bad || line_bad_now) && frame_len_ok) begin
            good_n = good_inc;
            if (good_inc == LOCK_CNT) state_n = LOCKED;
          end else begin
            good_n = '0;
          end
        end else if (hfall) begin
          line_bad_n = line_bad | line_bad_now;
        end
      end
      LOCKED: begin
        if (timeout || line_bad_now || (vfall && !frame_len_ok)) begin
          lock_err = 1'b1;
          state_n  = SEARCH;
        end
      end
      default: state_n = SEARCH;
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_err       <= 1'b0;
      bright_err_cnt <= '0;
    end else begin
      sync_err <= timeout | lock_err;
      if (pix_ce && state == LOCKED && bright_in != bright_exp && bright_err_cnt != '1)
        bright_err_cnt <= bright_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on scaled-down timing (40x12 frame),
// driven by a small behavioural generator with registered bright.
module tb_vga_sync_decoder;

  localparam int unsigned HT = 40, VT = 12, HO = 8, VO = 3, AW = 20, AH = 6;
  localparam int unsigned HS = 4, VS = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic        bright_in = 1'b0;
  logic [9:0]  x_out, y_out, line_len, frame_lines;
  logic        locked, sync_err;
  logic [15:0] bright_err_cnt;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_OFFSET(HO), .V_OFFSET(VO),
    .ACTIVE_W(AW), .ACTIVE_H(AH), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .bright_in(bright_in),
    .x_out(x_out), .y_out(y_out), .locked(locked), .sync_err(sync_err),
    .bright_err_cnt(bright_err_cnt), .line_len(line_len), .frame_lines(frame_lines)
  );

  int n_pass = 0, n_total = 0, serr_cnt = 0;

  always @(negedge clk) if (sync_err === 1'b1) serr_cnt++;

  typedef struct {
    logic h, v, b;
    logic [9:0] x, y, ll, fl;
  } vec_t;
  vec_t tbl [12];

  logic [9:0]  s_x, s_y, s_ll, s_fl;
  logic        s_lk, s_se;
  logic [15:0] s_berr;

  int   gx, gy, short_y;
  logic gbright;
  bit   hold_h, force_b, short_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic expb(input int px, input int py);
    return (px > int'(HO)) && (px < int'(HO + AW)) && (py > int'(VO)) && (py < int'(VO + AH));
  endfunction

  // One pixel: ce for one clk, snapshot the outputs half a clk after that edge.
  task automatic pix(input logic h, input logic v, input logic b);
    @(negedge clk);
    hsync_in = h; vsync_in = v; bright_in = b; pix_ce = 1'b1;
    @(negedge clk);
    pix_ce = 1'b0;
    s_x = x_out; s_y = y_out; s_ll = line_len; s_fl = frame_lines;
    s_lk = locked; s_se = sync_err; s_berr = bright_err_cnt;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic gen_reset();
    gx = 0; gy = 0; gbright = 1'b0;
    hold_h = 1'b0; force_b = 1'b0; short_en = 1'b0; short_y = 0;
  endtask

  task automatic gpix();
    logic h, v, b;
    int hlen;
    h = hold_h ? 1'b1 : (gx < int'(HS) ? 1'b0 : 1'b1);
    v = (gy < int'(VS)) ? 1'b0 : 1'b1;
    b = hold_h ? 1'b0 : (force_b ? 1'b1 : gbright);
    pix(h, v, b);
    gbright = expb(gx, gy);
    hlen = (short_en && gy == short_y) ? int'(HT) - 1 : int'(HT);
    gx++;
    if (gx >= hlen) begin
      gx = 0;
      if (short_en && gy == short_y) short_en = 1'b0;
      gy = (gy + 1) % int'(VT);
    end
  endtask

  task automatic wait_frames(input int n, input string name);
    int seen = 0;
    bit fs;
    for (int i = 0; i < (n + 1) * int'(HT * VT) && seen < n; i++) begin
      fs = (gx == 0 && gy == 0);
      gpix();
      if (fs) seen++;
    end
    chk({name, "_frames_seen"}, 64'(seen), 64'(n));
  endtask

  task automatic step_to(input int tx, input int ty, input string name);
    for (int i = 0; i < int'(HT * VT) + 1 && !(gx == tx && gy == ty); i++) gpix();
    chk({name, "_reached"}, {32'(gx), 32'(gy)}, {32'(tx), 32'(ty)});
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {x_out, y_out, line_len, frame_lines, locked, sync_err, bright_err_cnt}, 64'd0);
  endtask

  initial begin
    int base;

    //                h     v     b     x      y      ll     fl
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 10'd1, 10'd0, 10'd0, 10'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 10'd2, 10'd0, 10'd0, 10'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 10'd0, 10'd1, 10'd3, 10'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 10'd1, 10'd1, 10'd3, 10'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 10'd2, 10'd1, 10'd3, 10'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd3, 10'd2};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 10'd1, 10'd0, 10'd3, 10'd2};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 10'd0, 10'd1, 10'd2, 10'd2};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 10'd1, 10'd1, 10'd2, 10'd2};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 10'd0, 10'd2, 10'd2, 10'd2};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 10'd1, 10'd2, 10'd2, 10'd2};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 10'd2, 10'd3};

    // Reset held 10 clk with random inputs
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      bright_in = 1'($urandom); pix_ce = 1'($urandom);
      chk($sformatf("reset_hold_%0d", i),
          {x_out, y_out, line_len, frame_lines, locked, sync_err, bright_err_cnt}, 64'd0);
    end
    @(negedge clk);
    pix_ce = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; bright_in = 1'b0;
    reset_n = 1'b1;

    // Edge/counter vectors; bright is never counted outside LOCKED
    for (int i = 0; i < 12; i++) begin
      pix(tbl[i].h, tbl[i].v, tbl[i].b);
      chk($sformatf("vec%0d", i), {s_x, s_y, s_ll, s_fl, s_lk, s_se, s_berr},
          {tbl[i].x, tbl[i].y, tbl[i].ll, tbl[i].fl, 1'b0, 1'b0, 16'd0});
    end

    // Nominal stream from reset
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    chk_reset_vals("reset_before_nominal");
    gen_reset();
    wait_frames(2, "nom_a");
    chk("nom_unlocked_after_2nd_vfall", 64'(s_lk), 64'd0);
    wait_frames(1, "nom_b");
    chk("nom_locked_after_3rd_vfall", 64'(s_lk), 64'd1);
    wait_frames(1, "nom_c");
    step_to(17, 5, "nom_coord");
    gpix();
    chk("nom_coord_xy", {s_x, s_y}, {10'd17, 10'd5});
    wait_frames(1, "nom_d");
    chk("nom_lengths", {s_ll, s_fl}, {10'(HT), 10'(VT)});
    chk("nom_bright_err", 64'(s_berr), 64'd0);
    chk("nom_locked_5frames", 64'(s_lk), 64'd1);
    chk("nom_no_sync_err", 64'(serr_cnt), 64'd0);

    // One 39-pixel line while locked
    short_en = 1'b1; short_y = 4;
    step_to(0, 5, "short");
    gpix();
    chk("short_err_pulse", {s_se, s_lk, s_ll}, {1'b1, 1'b0, 10'(HT - 1)});
    gpix();
    chk("short_pulse_ends", 64'(s_se), 64'd0);
    chk("short_pulse_count", 64'(serr_cnt), 64'd1);
    wait_frames(2, "short_relock_a");
    chk("short_not_yet_locked", 64'(s_lk), 64'd0);
    wait_frames(1, "short_relock_b");
    chk("short_relocked", 64'(s_lk), 64'd1);

    // Forced bright outside the window for 3 pixels
    step_to(3, 1, "bright");
    force_b = 1'b1;
    repeat (3) gpix();
    force_b = 1'b0;
    gpix();
    chk("bright_err_3", 64'(s_berr), 64'd3);
    chk("bright_stays_locked", {s_lk, s_se}, {1'b1, 1'b0});

    // Stuck-high hsync: timeout at saturation, single pulse
    step_to(0, 6, "hold");
    base = serr_cnt;
    hold_h = 1'b1;
    for (int i = 0; i < 1100 && s_x != 10'd1023; i++) gpix();
    chk("hold_timeout", {s_x, s_se, s_lk}, {10'd1023, 1'b1, 1'b0});
    repeat (50) gpix();
    chk("hold_saturated", 64'(s_x), 64'd1023);
    chk("hold_single_pulse", 64'(serr_cnt - base), 64'd1);
    step_to(0, 5, "hold_release");
    hold_h = 1'b0;
    wait_frames(2, "hold_relock_a");
    chk("hold_not_yet_locked", 64'(s_lk), 64'd0);
    wait_frames(1, "hold_relock_b");
    chk("hold_relocked", {s_lk, s_berr}, {1'b1, 16'd3});

    // Reset pulse mid-frame while locked
    step_to(20, 5, "midreset");
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("midreset_values");
    reset_n = 1'b1;
    wait_frames(2, "midreset_relock_a");
    chk("midreset_not_yet_locked", 64'(s_lk), 64'd0);
    wait_frames(1, "midreset_relock_b");
    chk("midreset_relocked", {s_lk, s_ll, s_fl, s_berr}, {1'b1, 10'(HT), 10'(VT), 16'd0});
    chk("total_sync_err_pulses", 64'(serr_cnt), 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
